bpred_gshare: RTL and testbench

BPRED_GSHARE -- requirements
Module: bpred_gshare

---
 rtl/bpred_gshare_pkg.sv | 35 +++
 rtl/bpred_fifo.sv | 61 ++++++
 rtl/bpred_gshare.sv | 111 +++++++++++
 tb/tb_bpred_gshare.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bpred_gshare_pkg.sv
// Shared definitions for the gshare branch predictor.
// Holds the 2-bit saturating counter state encodings, the in-flight FIFO
// entry layout and the counter update helper.
package bpred_gshare_pkg;

    // 2-bit saturating counter states; the MSB is the taken prediction.
    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    // Entry fields are sized for the widest supported index; narrower
    // configurations use the low IDX_W bits and leave the rest zero.
    localparam int ENTRY_IDX_W = 16;

    typedef struct packed {
        logic [ENTRY_IDX_W-1:0] idx;
        logic                   pred;
        logic [ENTRY_IDX_W-1:0] ghr;
    } fifo_entry_t;

    // Saturating increment on taken, saturating decrement on not taken.
    function automatic logic [1:0] ctr_update(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        case (cur)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = WEAK_NT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bpred_fifo.sv
// In-flight prediction FIFO.
// Ports: clk/reset (async active-high), flush (synchronous, empties FIFO),
// push/wdata (ignored when full), pop (ignored when empty), rdata (head,
// combinational), full/empty (combinational flags).
// Pointers carry one extra bit so full and empty can be told apart.
module bpred_fifo
    import bpred_gshare_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  fifo_entry_t wdata,
    input  logic        pop,
    output fifo_entry_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);

    fifo_entry_t   mem_r [DEPTH];
    logic [PW:0]   wr_ptr_r;
    logic [PW:0]   rd_ptr_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign rdata     = mem_r[rd_ptr_r[PW-1:0]];
    assign do_push_s = push & ~full & ~flush;
    assign do_pop_s  = pop & ~empty & ~flush;

    // Pointer update; flush discards everything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/bpred_gshare.sv
// Gshare branch predictor.
// Ports: clk, reset (async active-high); lookup_valid/lookup_pc/lookup_ready
// request a prediction, answered one cycle later on predict_valid/
// predict_taken; resolve_valid/resolve_taken retire the oldest in-flight
// branch, mispredict flags a wrong prediction one cycle later;
// fifo_empty reports no branches in flight.
module bpred_gshare
    import bpred_gshare_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        lookup_ready,
    output logic        predict_valid,
    output logic        predict_taken,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    output logic        mispredict,
    output logic        fifo_empty
);

    logic [1:0]       ctr_r [2**IDX_W];
    logic [IDX_W-1:0] ghr_r;
    logic [IDX_W-1:0] ghr_next_s;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] head_idx_s;
    logic             pred_s;
    logic             fifo_full_s;
    logic             res_acc_s;
    logic             misp_s;
    logic             lk_acc_s;
    fifo_entry_t      push_entry_s;
    fifo_entry_t      head_s;
    logic             unused_s;

    assign idx_s        = lookup_pc[IDX_W+1:2] ^ ghr_r;
    assign pred_s       = ctr_r[idx_s][1];
    assign head_idx_s   = head_s.idx[IDX_W-1:0];
    assign lookup_ready = ~fifo_full_s;
    assign res_acc_s    = resolve_valid & ~fifo_empty;
    assign misp_s       = res_acc_s & (head_s.pred != resolve_taken);
    // A mispredicting resolve redirects fetch, so a same-cycle lookup is dropped.
    assign lk_acc_s     = lookup_valid & lookup_ready & ~misp_s;
    assign unused_s     = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0], head_s};

    // Build the entry pushed for an accepted lookup.
    always_comb begin
        push_entry_s                 = '0;
        push_entry_s.idx[IDX_W-1:0]  = idx_s;
        push_entry_s.pred            = pred_s;
        push_entry_s.ghr[IDX_W-1:0]  = ghr_r;
    end

    // Speculative history: repaired from the head's saved copy on mispredict.
    always_comb begin
        if (misp_s) begin
            ghr_next_s = {head_s.ghr[IDX_W-2:0], resolve_taken};
        end else if (lk_acc_s) begin
            ghr_next_s = {ghr_r[IDX_W-2:0], pred_s};
        end else begin
            ghr_next_s = ghr_r;
        end
    end

    bpred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (misp_s),
        .push  (lk_acc_s),
        .wdata (push_entry_s),
        .pop   (res_acc_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty)
    );

    // Counter table training on each accepted resolve.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**IDX_W; i++) begin
                ctr_r[i] <= WEAK_NT;
            end
        end else if (res_acc_s) begin
            ctr_r[head_idx_s] <= ctr_update(ctr_r[head_idx_s], resolve_taken);
        end
    end

    // History register and registered prediction/mispredict outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_r         <= {IDX_W{1'b0}};
            predict_valid <= 1'b0;
            predict_taken <= 1'b0;
            mispredict    <= 1'b0;
        end else begin
            ghr_r         <= ghr_next_s;
            predict_valid <= lk_acc_s;
            mispredict    <= misp_s;
            if (lk_acc_s) begin
                predict_taken <= pred_s;
            end
        end
    end

endmodule

// File: tb/tb_bpred_gshare.sv
// Randomized and directed bench for bpred_gshare with a queue-based
// reference model and a scoreboard for the registered outputs.
module tb_bpred_gshare;

    localparam int IDX_W = 4;
    localparam int DEPTH = 4;
    localparam int NCTR  = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = 32'd0;
    logic        lookup_ready;
    logic        predict_valid;
    logic        predict_taken;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic        mispredict;
    logic        fifo_empty;

    bpred_gshare #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .lookup_valid  (lookup_valid),
        .lookup_pc     (lookup_pc),
        .lookup_ready  (lookup_ready),
        .predict_valid (predict_valid),
        .predict_taken (predict_taken),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .mispredict    (mispredict),
        .fifo_empty    (fifo_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit pred;
        int ghr;
    } inflight_t;

    typedef struct {
        bit pv;
        bit pt;
        bit mp;
    } exp_t;

    // Reference model state: counters as plain integers 0..3.
    int        m_ctr [NCTR];
    int        m_ghr;
    bit        m_last_pt;
    inflight_t m_q[$];
    exp_t      exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCTR; i++) m_ctr[i] = 1;
        m_ghr     = 0;
        m_last_pt = 1'b0;
        m_q.delete();
    endtask

    // One cycle of stimulus: drive, check combinational flags, advance model.
    task automatic step(input bit lv, input logic [31:0] pc, input bit rv, input bit rt);
        bit        full, empty, res_acc, misp, lk, pred;
        int        idx;
        inflight_t h, e;
        exp_t      x;
        @(negedge clk);
        reset         = 1'b0;
        lookup_valid  = lv;
        lookup_pc     = pc;
        resolve_valid = rv;
        resolve_taken = rt;
        #1;
        empty = (m_q.size() == 0);
        full  = (m_q.size() == DEPTH);
        check("lookup_ready", int'(lookup_ready), int'(!full));
        check("fifo_empty", int'(fifo_empty), int'(empty));
        res_acc = rv && !empty;
        misp    = res_acc && (m_q[0].pred != rt);
        idx     = ((pc >> 2) % NCTR) ^ m_ghr;
        pred    = (m_ctr[idx] >= 2);
        lk      = lv && !full && !misp;
        if (res_acc) begin
            h = m_q.pop_front();
            if (rt) m_ctr[h.idx] = (m_ctr[h.idx] == 3) ? 3 : m_ctr[h.idx] + 1;
            else    m_ctr[h.idx] = (m_ctr[h.idx] == 0) ? 0 : m_ctr[h.idx] - 1;
            if (misp) begin
                m_q.delete();
                m_ghr = ((h.ghr * 2) + int'(rt)) % NCTR;
            end
        end
        if (lk) begin
            e.idx = idx; e.pred = pred; e.ghr = m_ghr;
            m_q.push_back(e);
            m_ghr     = ((m_ghr * 2) + int'(pred)) % NCTR;
            m_last_pt = pred;
        end
        x.pv = lk; x.pt = m_last_pt; x.mp = misp;
        exp_q.push_back(x);
    endtask

    // Reset asserted mid-cycle; entries vanish immediately.
    task automatic do_reset();
        exp_t x;
        @(negedge clk);
        reset         = 1'b1;
        lookup_valid  = 1'b0;
        resolve_valid = 1'b0;
        #1;
        model_reset();
        check("reset_fifo_empty", int'(fifo_empty), 1);
        check("reset_pv", int'(predict_valid), 0);
        check("reset_mp", int'(mispredict), 0);
        x.pv = 1'b0; x.pt = 1'b0; x.mp = 1'b0;
        exp_q.push_back(x);
    endtask

    // Scoreboard monitor: compare registered outputs after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("predict_valid", int'(predict_valid), int'(x.pv));
                check("predict_taken", int'(predict_taken), int'(x.pt));
                check("mispredict", int'(mispredict), int'(x.mp));
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("por_fifo_empty", int'(fifo_empty), 1);
        check("por_pv", int'(predict_valid), 0);

        // First lookup after reset predicts not taken.
        step(1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Train pc 0x10 toward taken; mispredict flushes repair history.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h10, 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b1, 1'b1);
        end
        step(1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);

        // Saturation: repeated taken then one not-taken on the same pc.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h20, 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b1, (i < 4));
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h24, 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end

        // Fill the FIFO, then an extra lookup is refused.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 32'h40 + i * 4, 1'b0, 1'b0);
        // Full with simultaneous correct resolve: lookup still refused.
        step(1'b1, 32'h80, 1'b1, 1'b0);
        // Drain one with a lookup in the same cycle.
        step(1'b1, 32'h84, 1'b1, 1'b0);
        // Mispredict on head flushes everything.
        step(1'b1, 32'h88, 1'b1, 1'b1);
        // Resolve on empty FIFO is ignored.
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0, 1'b0, 1'b0);

        // Three in flight, head mispredicts.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + i * 8, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b0);

        // Reset with two in flight.
        step(1'b1, 32'h30, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 32'h30, 1'b0, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 99) < 65), $urandom,
                     ($urandom_range(0, 99) < 50), $urandom_range(0, 1) == 1);
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
